// File: rtl/tim_pscr_tick_gen.sv
// Timer prescaler tick generator.
//
// Divides the clock by a run-time loadable divisor and emits a single-cycle
// count-enable pulse (tick) once per divisor period for the downstream timer
// counter. A new divisor is loaded through a valid/ready handshake. Loading
// always passes through a one-cycle LOAD state, during which the block
// refuses further divisors.
//
// Parameters
//   DIV_WIDTH   width of the divisor and of the prescale count
//   DEF_DIV     divisor in effect after reset
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-high reset
//   en_i         count enable (IDLE <-> RUN)
//   div_i        requested divisor (0 is treated as 1)
//   div_valid_i  divisor load request
//   div_ready_o  block can accept a divisor (low only in LOAD)
//   div_done_o   current divisor is loaded and in effect
//   tick_o       single-cycle prescaled count-enable pulse
//   div_q_o      effective divisor
//   cnt_o        current prescale count
//
// Every output is a flop; nothing reaches an output combinationally.

module tim_pscr_tick_gen #(
    parameter int          DIV_WIDTH = 20,
    parameter int unsigned DEF_DIV   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_done_o,
    output logic                 tick_o,
    output logic [DIV_WIDTH-1:0] div_q_o,
    output logic [DIV_WIDTH-1:0] cnt_o
);

    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] ZERO      = '0;
    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEF_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state;

    // The counter has reached the last count of the period. The subtraction
    // stays within DIV_WIDTH bits because the effective divisor is never 0,
    // so the all-ones divisor still yields a full-length period.
    logic at_wrap;
    assign at_wrap = (cnt_o == (div_q_o - ONE));

    // Single state machine with registered outputs.
    // Priority: reset, then an accepted handshake, then the state behaviour.
    // An accepted handshake therefore wins over en_i and over a coincident
    // wrap, whose tick is dropped.
    //
    // Entering RUN from IDLE starts the period at count 0; with a divisor of
    // 1 every RUN cycle is a tick, including the first.
    // Leaving LOAD into RUN treats the LOAD cycle itself as count 0 of the
    // new period, so the normal step rule is applied to the cleared count and
    // the first tick lands exactly div_q_o cycles after the LOAD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt_o       <= ZERO;
            tick_o      <= 1'b0;
            div_q_o     <= RESET_DIV;
            div_ready_o <= 1'b1;
            div_done_o  <= 1'b1;
        end else if (div_valid_i && div_ready_o) begin
            state       <= LOAD;
            div_q_o     <= (div_i == ZERO) ? ONE : div_i;
            cnt_o       <= ZERO;
            tick_o      <= 1'b0;
            div_ready_o <= 1'b0;
            div_done_o  <= 1'b0;
        end else begin
            div_ready_o <= 1'b1;
            div_done_o  <= 1'b1;
            case (state)
                IDLE: begin
                    cnt_o <= ZERO;
                    if (en_i) begin
                        state  <= RUN;
                        tick_o <= (div_q_o == ONE);
                    end else begin
                        tick_o <= 1'b0;
                    end
                end
                RUN, LOAD: begin
                    if (en_i) begin
                        state <= RUN;
                        if (at_wrap) begin
                            cnt_o  <= ZERO;
                            tick_o <= 1'b1;
                        end else begin
                            cnt_o  <= cnt_o + ONE;
                            tick_o <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        cnt_o  <= ZERO;
                        tick_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt_o  <= ZERO;
                    tick_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tim_pscr_tick_gen.sv
// Scoreboard testbench for tim_pscr_tick_gen.
//
// The stimulus process drives one directed vector per clock on the falling
// edge and pushes the hand-computed outputs expected after the next rising
// edge into a queue. An independent monitor pops one entry per rising edge
// (sampled 1 ns later) and compares it with the DUT outputs.
// A narrow DIV_WIDTH is used so the all-ones divisor period is short.

module tb_tim_pscr_tick_gen;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] div;
    logic          divValid;
    logic          divReady;
    logic          divDone;
    logic          tick;
    logic [DW-1:0] divQ;
    logic [DW-1:0] cnt;

    typedef struct {
        logic [DW-1:0] cnt;
        logic          tick;
        logic [DW-1:0] divQ;
        logic          ready;
        logic          done;
    } exp_t;

    exp_t expQ[$];

    int vectors     = 0;
    int miscompares = 0;

    tim_pscr_tick_gen #(
        .DIV_WIDTH(DW),
        .DEF_DIV  (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .div_i      (div),
        .div_valid_i(divValid),
        .div_ready_o(divReady),
        .div_done_o (divDone),
        .tick_o     (tick),
        .div_q_o    (divQ),
        .cnt_o      (cnt)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector on the falling edge and queue what the outputs must
    // show after the following rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [DW-1:0] d,
                                 input logic [DW-1:0] eCnt, input logic eTick,
                                 input logic [DW-1:0] eDivQ,
                                 input logic eReady, input logic eDone);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        divValid = v;
        div      = d;
        x.cnt    = eCnt;
        x.tick   = eTick;
        x.divQ   = eDivQ;
        x.ready  = eReady;
        x.done   = eDone;
        expQ.push_back(x);
    endtask

    // Compare one expected record with the sampled DUT outputs.
    task automatic checkOutput(input exp_t x, input int idx);
        vectors++;
        if (cnt !== x.cnt || tick !== x.tick || divQ !== x.divQ ||
            divReady !== x.ready || divDone !== x.done) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got cnt=%0d tick=%b div_q=%0d ready=%b done=%b, expected cnt=%0d tick=%b div_q=%0d ready=%b done=%b",
                     idx, cnt, tick, divQ, divReady, divDone,
                     x.cnt, x.tick, x.divQ, x.ready, x.done);
        end
    endtask

    // Monitor: one comparison per rising edge while expectations are pending.
    initial begin
        int idx;
        exp_t x;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                idx++;
                checkOutput(x, idx);
            end
        end
    end

    // Directed vectors: r, en, valid, div  ->  cnt, tick, div_q, ready, done
    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        divValid = 1'b0;
        div      = '0;

        // Reset, held with enable and a coincident handshake that must be ignored.
        applyStimulus(1, 0, 0, 0,   0, 0, 1, 1, 1);
        applyStimulus(1, 1, 1, 7,   0, 0, 1, 1, 1);

        // Default divisor 1: tick on every RUN cycle from the first.
        applyStimulus(0, 1, 0, 0,   0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0,   0, 0, 1, 1, 1);

        // Load 4 while idle, then count 0,1,2,3,0 with ticks 4 apart.
        applyStimulus(0, 0, 1, 4,   0, 0, 4, 0, 0);
        applyStimulus(0, 0, 0, 0,   0, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   1, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   2, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   3, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   1, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   2, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   3, 0, 4, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 4, 1, 1);

        // Load 0 becomes 1; a request during LOAD is refused.
        applyStimulus(0, 1, 1, 0,   0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 9,   0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 1, 1, 1);

        // Load 5; div_i changes after the accept edge have no effect.
        applyStimulus(0, 1, 1, 5,   0, 0, 5, 0, 0);
        applyStimulus(0, 1, 0, 3,   1, 0, 5, 1, 1);
        applyStimulus(0, 1, 0, 3,   2, 0, 5, 1, 1);
        applyStimulus(0, 1, 0, 0,   3, 0, 5, 1, 1);
        applyStimulus(0, 1, 0, 0,   4, 0, 5, 1, 1);

        // Handshake on the wrap edge: tick dropped, next tick 3 after LOAD.
        applyStimulus(0, 1, 1, 3,   0, 0, 3, 0, 0);
        applyStimulus(0, 1, 0, 0,   1, 0, 3, 1, 1);
        applyStimulus(0, 1, 0, 0,   2, 0, 3, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 3, 1, 1);
        applyStimulus(0, 1, 0, 0,   1, 0, 3, 1, 1);

        // Divisor 8, disable at count 5, re-enable: tick 8 after first RUN cycle.
        applyStimulus(0, 1, 1, 8,   0, 0, 8, 0, 0);
        for (int k = 1; k <= 5; k++)
            applyStimulus(0, 1, 0, 0, DW'(k), 0, 8, 1, 1);
        applyStimulus(0, 0, 0, 0,   0, 0, 8, 1, 1);
        applyStimulus(0, 0, 0, 0,   0, 0, 8, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 0, 8, 1, 1);
        for (int k = 1; k <= 7; k++)
            applyStimulus(0, 1, 0, 0, DW'(k), 0, 8, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 8, 1, 1);

        // Reset during LOAD of 7 with a coincident request: default divisor back.
        applyStimulus(0, 1, 1, 7,   0, 0, 7, 0, 0);
        applyStimulus(1, 1, 1, 7,   0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0,   0, 0, 1, 1, 1);

        // All-ones divisor: full 15-cycle period without overflow.
        applyStimulus(0, 0, 1, 15,  0, 0, 15, 0, 0);
        for (int k = 1; k <= 14; k++)
            applyStimulus(0, 1, 0, 0, DW'(k), 0, 15, 1, 1);
        applyStimulus(0, 1, 0, 0,   0, 1, 15, 1, 1);
        applyStimulus(0, 1, 0, 0,   1, 0, 15, 1, 1);

        // Let the monitor drain the queue, with a bounded wait.
        for (int w = 0; w < 20 && expQ.size() > 0; w++)
            @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0",
                     expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
